uart_tx_fifo_param: RTL and testbench
=====================================

// Module: uart_tx_fifo_param
// PURPOSE
//  Parametrised UART transmitter with an input FIFO: configurable data width, parity and stop bits.
//  Upstream pushes words through a valid/ready handshake. Queued words go out back-to-back
//  with no idle gap between frames. Replaces the single-byte, pulse-started TX in the UART
//  datapath; a serialiser/controller drives it from the same Clock domain.
// PARAMETERS
//  CLKS_PER_BIT  868  Clock cycles per bit = f_clk / baud (>= 2); 868 = 100 MHz / 115200
//  DATA_BITS     8    Data bits per frame, 5..9, sent LSB first
//  PARITY        0    0 = none, 1 = odd, 2 = even
//  STOP_BITS     1    Stop bits per frame, 1 or 2
//  FIFO_DEPTH    4    Input FIFO entries, power of 2, >= 2
// PORTS
//  Clock       in   1                         System clock, all logic on rising edge
//  Reset_n     in   1                         Asynchronous, active-low reset
//  TX_Valid    in   1                         Upstream word valid
//  TX_Bytes    in   DATA_BITS                 Word to send; sampled when TX_Valid && TX_Ready
//  TX_Ready    out  1                         FIFO not full, push accepted this cycle
//  TX_Serial   out  1                         Serial line, idles high
//  TX_Active   out  1                         High from start-bit begin to the last stop-bit cycle
//  TX_Done     out  1                         One-cycle pulse at the end of each frame
//  FIFO_Count  out  $clog2(FIFO_DEPTH)+1      Words queued, not counting the frame in flight
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - Outputs: TX_Serial=1, TX_Active=0, TX_Done=0, TX_Ready=1, FIFO_Count=0.
//   - FIFO pointers cleared and state returns to IDLE.
//   - Mid-frame reset aborts the frame immediately; the line goes high at once.
//  FIFO
//   - Push when TX_Valid && TX_Ready. TX_Ready = (FIFO_Count != FIFO_DEPTH), registered view.
//   - A push while full is impossible (TX_Ready=0); TX_Valid is ignored then.
//   - Push and pop in the same cycle: the count is unchanged, both take effect.
//   - Pointers wrap modulo FIFO_DEPTH.
//  State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> (START | IDLE)
//   - IDLE: TX_Serial=1. If FIFO non-empty: pop into shift register, compute parity,
//     TX_Serial<=0, TX_Active<=1, go START.
//   - Latency: word pushed at edge N into an empty FIFO while IDLE -> TX_Serial low after edge N+2.
//   - Every bit lasts exactly CLKS_PER_BIT cycles.
//     Bit counter width is $clog2(CLKS_PER_BIT); it restarts at 0 on each bit.
//   - DATA: DATA_BITS bits, LSB first. Index 0..DATA_BITS-1.
//   - PARITY (only if PARITY!=0): even = XOR of data bits; odd = its inverse.
//   - STOP: line high for STOP_BITS*CLKS_PER_BIT cycles.
//  End of frame (last STOP cycle)
//   - TX_Done pulses for 1 cycle.
//   - FIFO non-empty: pop on the same edge, go directly to START with TX_Active held high,
//     so the start bit immediately follows the stop bit.
//   - FIFO empty: go IDLE, TX_Active<=0.
//  Frame length = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles, exact.
//  Other rules
//   - TX_Bytes changes after acceptance never affect a queued or in-flight word.
//   - Illegal parameter values are caught by an elaboration-time check (fatal $error).
// TESTING (bench uses CLKS_PER_BIT=16 unless stated)
//  1 Reset: after Reset_n low -> TX_Serial=1, TX_Ready=1, FIFO_Count=0, TX_Active=0.
//    Reset mid-data-bit -> TX_Serial=1 in the same cycle; a later frame is clean.
//  2 8N1: push 8'hA5 -> line 0,1,0,1,0,0,1,0,1,1, each 16 cycles; TX_Done one pulse at cycle 160.
//  3 7E2 and 7O1: push 7'h15 -> parity bit 1 (even) or 0 (odd).
//    Frame lengths 176 and 160 cycles respectively.
//  4 Burst: push 6 words with FIFO_DEPTH=4 -> TX_Ready drops when 4 are queued.
//    All 6 frames are back-to-back with no gap; TX_Active stays high throughout; 6 TX_Done pulses.
//  5 Simultaneous: push on the exact cycle the FIFO pops at end of frame -> FIFO_Count unchanged.
//    Word order is preserved.
//  6 9-bit: DATA_BITS=9, PARITY=2, push 9'h1FF -> 9 ones then parity 1; frame 192 cycles.

Source files
------------

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter fed by a small word FIFO: configurable data width, parity and stop bits.
// Queued words leave back-to-back; the start bit of the next frame follows the last stop cycle.
module uart_tx_fifo_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic                          TX_Valid,
  input  logic [DATA_BITS-1:0]          TX_Bytes,
  output logic                          TX_Ready,
  output logic                          TX_Serial,
  output logic                          TX_Active,
  output logic                          TX_Done,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_Count,
  output logic [2:0]                    dbg_state
);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_fifo_param: illegal parameter set");
  end

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = 4;
  localparam logic [CW-1:0]   CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]   DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0]   STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [CNTW-1:0] DEPTH     = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [DATA_BITS-1:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CNTW-1:0]       count, count_next;
  logic                  fifo_avail;
  logic                  has_word, push, pop, bit_end, frame_end;
  logic [CW-1:0]         clk_cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  parity_bit;

  // Handshake: a word transfers on a rising edge where TX_Valid and TX_Ready are both high;
  // TX_Ready is registered and depends only on the queue occupancy.
  assign push      = TX_Valid && TX_Ready;
  assign has_word  = (count != '0);
  assign bit_end   = (clk_cnt == CLK_LAST);
  assign frame_end = (state == S_STOP) && bit_end && (bit_idx == STOP_LAST);
  // IDLE waits on the registered non-empty view, which sets the two-edge start latency.
  assign pop       = ((state == S_IDLE) && fifo_avail && has_word) || (frame_end && has_word);

  assign FIFO_Count = count;
  assign dbg_state  = state;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      TX_Ready   <= 1'b1;
      fifo_avail <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      TX_Ready   <= (count_next != DEPTH);
      fifo_avail <= has_word;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifo_mem[wr_ptr] <= TX_Bytes;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (pop) state_next = S_START;
      S_START:  if (bit_end) state_next = S_DATA;
      S_DATA:   if (bit_end && bit_idx == DATA_LAST)
                  state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_next = S_STOP;
      S_STOP:   if (frame_end) state_next = has_word ? S_START : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // bit_idx counts data bits in DATA and stop bits in STOP; it clears on every state change.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      if (state == S_IDLE || bit_end) clk_cnt <= '0;
      else                            clk_cnt <= clk_cnt + 1'b1;
      if (state_next != state) bit_idx <= '0;
      else if (bit_end)        bit_idx <= bit_idx + 1'b1;
      if (pop) begin
        shift_reg  <= fifo_mem[rd_ptr];
        parity_bit <= (PARITY == 1) ? ~^fifo_mem[rd_ptr] : ^fifo_mem[rd_ptr];
      end else if (state == S_DATA && bit_end) begin
        shift_reg <= shift_reg >> 1;
      end
    end
  end

  always_comb begin
    TX_Serial = 1'b1;
    TX_Active = 1'b1;
    TX_Done   = 1'b0;
    case (state)
      S_IDLE:   TX_Active = 1'b0;
      S_START:  TX_Serial = 1'b0;
      S_DATA:   TX_Serial = shift_reg[0];
      S_PARITY: TX_Serial = parity_bit;
      S_STOP:   TX_Done   = frame_end;
      default:  TX_Active = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: four configurations (8N1, 7E2, 7O1, 9E1) share one clock;
// a per-instance line decoder checks every frame against words queued by the stimulus.
module tb_uart_tx_fifo_param;

  localparam int CPB = 16;
  localparam int NI  = 4;
  localparam int DB  [NI] = '{8, 7, 7, 9};
  localparam int PAR [NI] = '{0, 2, 1, 2};
  localparam int SB  [NI] = '{1, 2, 1, 1};

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] valid = '0;
  logic [8:0]    data  [NI];
  wire  [NI-1:0] ready, serial, active, done;
  wire  [2:0]    cnt   [NI];
  wire  [2:0]    dbg   [NI];

  logic [8:0]  exp_q    [NI][$];
  int          starts   [NI][$];
  logic [15:0] last_obs [NI];
  int          stray_done [NI];
  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB[0]), .PARITY(PAR[0]), .STOP_BITS(SB[0]), .FIFO_DEPTH(4)) u_8n1 (
    .Clock(clk), .Reset_n(rst_n), .TX_Valid(valid[0]), .TX_Bytes(data[0][7:0]), .TX_Ready(ready[0]),
    .TX_Serial(serial[0]), .TX_Active(active[0]), .TX_Done(done[0]), .FIFO_Count(cnt[0]), .dbg_state(dbg[0]));
  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB[1]), .PARITY(PAR[1]), .STOP_BITS(SB[1]), .FIFO_DEPTH(4)) u_7e2 (
    .Clock(clk), .Reset_n(rst_n), .TX_Valid(valid[1]), .TX_Bytes(data[1][6:0]), .TX_Ready(ready[1]),
    .TX_Serial(serial[1]), .TX_Active(active[1]), .TX_Done(done[1]), .FIFO_Count(cnt[1]), .dbg_state(dbg[1]));
  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB[2]), .PARITY(PAR[2]), .STOP_BITS(SB[2]), .FIFO_DEPTH(4)) u_7o1 (
    .Clock(clk), .Reset_n(rst_n), .TX_Valid(valid[2]), .TX_Bytes(data[2][6:0]), .TX_Ready(ready[2]),
    .TX_Serial(serial[2]), .TX_Active(active[2]), .TX_Done(done[2]), .FIFO_Count(cnt[2]), .dbg_state(dbg[2]));
  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB[3]), .PARITY(PAR[3]), .STOP_BITS(SB[3]), .FIFO_DEPTH(4)) u_9e1 (
    .Clock(clk), .Reset_n(rst_n), .TX_Valid(valid[3]), .TX_Bytes(data[3][8:0]), .TX_Ready(ready[3]),
    .TX_Serial(serial[3]), .TX_Active(active[3]), .TX_Done(done[3]), .FIFO_Count(cnt[3]), .dbg_state(dbg[3]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int frame_len(input int k);
    return 1 + DB[k] + ((PAR[k] != 0) ? 1 : 0) + SB[k];
  endfunction

  function automatic logic [8:0] mask(input int k, input logic [8:0] w);
    logic [8:0] m;
    m = 9'((32'd1 << DB[k]) - 1);
    return w & m;
  endfunction

  // Line image of one frame, bit 0 = start bit, then data LSB first, parity, stop bits.
  function automatic logic [15:0] frame_bits(input int k, input logic [8:0] w);
    logic [15:0] f;
    int p;
    f = '0;
    for (int i = 0; i < DB[k]; i++) f[1+i] = w[i];
    p = 1 + DB[k];
    if (PAR[k] != 0) begin
      f[p] = (^w) ^ (PAR[k] == 1);
      p++;
    end
    for (int s = 0; s < SB[k]; s++) f[p+s] = 1'b1;
    return f;
  endfunction

  task automatic push_word(input int k, input logic [8:0] w);
    int guard = 0;
    @(negedge clk);
    while (!ready[k] && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check_eq($sformatf("push_wait_ready[%0d]", k), 32'(guard < 4000), 1);
    valid[k] = 1'b1;
    data[k]  = w;
    exp_q[k].push_back(mask(k, w));
    @(negedge clk);
    valid[k] = 1'b0;
    data[k]  = 9'($urandom);
  endtask

  task automatic drain(input int k);
    int guard = 0;
    while ((exp_q[k].size() != 0 || active[k]) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check_eq($sformatf("drain_in_time[%0d]", k), 32'(guard < 20000), 1);
    check_eq($sformatf("count_after_drain[%0d]", k), 32'(cnt[k]), 0);
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_mon
    initial begin
      logic [8:0]  w;
      logic [15:0] expb, obs;
      int nb, unstable, inactive, done_hits, done_at;
      stray_done[g] = 0;
      forever begin
        @(negedge clk);
        if (mon_en && rst_n && serial[g] === 1'b0) begin
          check_eq($sformatf("start_has_word[%0d]", g), 32'(exp_q[g].size() != 0), 1);
          if (exp_q[g].size() != 0) begin
            w = exp_q[g].pop_front();
            expb = frame_bits(g, w);
            nb = frame_len(g);
            obs = '0; unstable = 0; inactive = 0; done_hits = 0; done_at = -1;
            starts[g].push_back(cyc);
            for (int b = 0; b < nb; b++) begin
              for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (c == 0) obs[b] = serial[g];
                else if (serial[g] !== obs[b]) unstable++;
                if (active[g] !== 1'b1) inactive++;
                if (done[g] === 1'b1) begin
                  done_hits++;
                  done_at = b * CPB + c;
                end
              end
            end
            check_eq($sformatf("frame_bits[%0d]", g), 32'(obs), 32'(expb));
            check_eq($sformatf("bit_stable[%0d]", g), unstable, 0);
            check_eq($sformatf("active_in_frame[%0d]", g), inactive, 0);
            check_eq($sformatf("done_pulses[%0d]", g), done_hits, 1);
            check_eq($sformatf("done_cycle[%0d]", g), done_at, nb * CPB - 1);
            last_obs[g] = obs;
          end else begin
            while (serial[g] === 1'b0) @(negedge clk);
          end
        end else if (mon_en && done[g] === 1'b1) begin
          stray_done[g]++;
        end
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, guard, i, max_cnt, n0;
    bit saw_full;
    logic [8:0] burst [6];

    for (int k = 0; k < NI; k++) data[k] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("reset_serial[%0d]", k), 32'(serial[k]), 1);
      check_eq($sformatf("reset_ready[%0d]", k), 32'(ready[k]), 1);
      check_eq($sformatf("reset_count[%0d]", k), 32'(cnt[k]), 0);
      check_eq($sformatf("reset_active[%0d]", k), 32'(active[k]), 0);
      check_eq($sformatf("reset_done[%0d]", k), 32'(done[k]), 0);
      check_eq($sformatf("reset_state_idle[%0d]", k), 32'(dbg[k]), 0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 8N1 0xA5 into an empty queue: start-bit latency and exact line image.
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 9'h0A5;
    exp_q[0].push_back(9'h0A5);
    @(negedge clk);
    valid[0] = 1'b0;
    check_eq("count_after_push", 32'(cnt[0]), 1);
    lat = 0;
    while (serial[0] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_eq("start_latency", lat, 2);
    drain(0);
    check_eq("frame_8n1_a5", 32'(last_obs[0]), 32'h034A);

    // Reset in the middle of a low data bit: line must rise without waiting for a clock.
    mon_en = 1'b0;
    push_word(0, 9'h055);
    guard = 0;
    while (serial[0] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    repeat (2 * CPB + CPB / 2) @(negedge clk);
    check_eq("pre_reset_line_low", 32'(serial[0]), 0);
    rst_n = 1'b0;
    #1;
    check_eq("midframe_reset_serial", 32'(serial[0]), 1);
    check_eq("midframe_reset_active", 32'(active[0]), 0);
    check_eq("midframe_reset_ready", 32'(ready[0]), 1);
    check_eq("midframe_reset_count", 32'(cnt[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q[0].delete();
    mon_en = 1'b1;
    push_word(0, 9'h03C);
    drain(0);

    // Parity variants and 9-bit data.
    push_word(1, 9'h015);
    push_word(2, 9'h015);
    push_word(3, 9'h1FF);
    drain(1);
    drain(2);
    drain(3);
    check_eq("frame_7e2_15", 32'(last_obs[1]), 32'h072A);
    check_eq("frame_7o1_15", 32'(last_obs[2]), 32'h022A);
    check_eq("frame_9e1_1ff", 32'(last_obs[3]), 32'h0FFE);

    // Burst of six words held valid: queue fills, frames run without gaps.
    for (int j = 0; j < 6; j++) burst[j] = 9'($urandom);
    n0 = starts[0].size();
    i = 0; guard = 0; saw_full = 1'b0; max_cnt = 0;
    while (i < 6 && guard < 2000) begin
      @(negedge clk);
      guard++;
      check_eq("ready_vs_count", 32'(ready[0]), 32'(cnt[0] != 3'd4));
      if (int'(cnt[0]) > max_cnt) max_cnt = int'(cnt[0]);
      if (!ready[0]) saw_full = 1'b1;
      valid[0] = 1'b1;
      data[0]  = burst[i];
      if (ready[0]) begin
        exp_q[0].push_back(mask(0, burst[i]));
        i++;
      end
    end
    @(negedge clk);
    valid[0] = 1'b0;
    drain(0);
    check_eq("burst_max_count", max_cnt, 4);
    check_eq("burst_ready_dropped", 32'(saw_full), 1);
    check_eq("burst_frames", starts[0].size() - n0, 6);
    for (int j = 1; j < 6 && n0 + j < starts[0].size(); j++)
      check_eq($sformatf("burst_spacing_%0d", j), starts[0][n0+j] - starts[0][n0+j-1], frame_len(0) * CPB);

    // Push on the very edge that pops the next word at end of frame.
    push_word(0, 9'h0C3);
    push_word(0, 9'h017);
    guard = 0;
    while (!done[0] && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check_eq("simul_done_seen", 32'(done[0]), 1);
    check_eq("simul_count_before", 32'(cnt[0]), 1);
    valid[0] = 1'b1;
    data[0]  = 9'h0E8;
    exp_q[0].push_back(9'h0E8);
    @(negedge clk);
    valid[0] = 1'b0;
    check_eq("simul_count_unchanged", 32'(cnt[0]), 1);
    drain(0);

    // Random words with random spacing on every configuration.
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 8; n++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(50, 300)) @(negedge clk);
        else repeat ($urandom_range(0, 2)) @(negedge clk);
        push_word(k, 9'($urandom));
      end
      drain(k);
    end

    repeat (5) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("queue_empty[%0d]", k), exp_q[k].size(), 0);
      check_eq($sformatf("stray_done[%0d]", k), stray_done[k], 0);
      check_eq($sformatf("idle_line[%0d]", k), 32'(serial[k]), 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
